// File: rtl/dot_batch_feeder_pkg.sv
// rtl/dot_batch_feeder_pkg.sv - shared constants and types for the dot batch feeder
package dot_pkg;
  localparam int N            = 128;
  localparam int WEIGHT_WIDTH = 4;
  localparam int ACT_WIDTH    = 4;
  localparam int LANES        = 8;
  localparam int RES_WIDTH    = 16;
  localparam int BEATS        = N / LANES;
  localparam int BEAT_W       = (BEATS > 1) ? $clog2(BEATS) : 1;

  typedef logic [N*WEIGHT_WIDTH-1:0]     weight_vec_t;
  typedef logic [N*ACT_WIDTH-1:0]        act_vec_t;
  typedef logic [LANES*WEIGHT_WIDTH-1:0] weight_beat_t;
  typedef logic [LANES*ACT_WIDTH-1:0]    act_beat_t;
  typedef logic signed [RES_WIDTH-1:0]   result_t;
endpackage

// File: rtl/dot_batch_feeder_if.sv
// rtl/dot_batch_feeder_if.sv - input stream, naive_dot link and result stream bundle
interface dot_batch_feeder_if;
  import dot_pkg::*;

  logic         s_valid;
  logic         s_ready;
  weight_beat_t s_weights;
  act_beat_t    s_acts;
  logic         o_start;
  weight_vec_t  o_weights_flat;
  act_vec_t     o_acts_flat;
  logic         i_done;
  result_t      i_result;
  logic         m_valid;
  logic         m_ready;
  result_t      m_result;

  modport slave (
    input  s_valid, s_weights, s_acts, i_done, i_result, m_ready,
    output s_ready, o_start, o_weights_flat, o_acts_flat, m_valid, m_result
  );

  modport master (
    output s_valid, s_weights, s_acts, i_done, i_result, m_ready,
    input  s_ready, o_start, o_weights_flat, o_acts_flat, m_valid, m_result
  );
endinterface

// File: rtl/dot_result_fifo.sv
// rtl/dot_result_fifo.sv - synchronous result FIFO with occupancy count
module dot_result_fifo
  import dot_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  result_t                  i_data,
  input  logic                     i_pop,
  output result_t                  o_data,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);
  localparam int AW = $clog2(DEPTH);

  result_t       r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_pop;

  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int k = 0; k < DEPTH; k++) r_mem[k] <= '0;
    end else begin
      if (i_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_count <= r_count + (AW+1)'(i_push) - (AW+1)'(w_pop);
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
endmodule

// File: rtl/dot_batch_feeder.sv
// rtl/dot_batch_feeder.sv - ping-pong batch assembler, naive_dot issuer and credit-protected result collector
module dot_batch_feeder
  import dot_pkg::*;
#(
  parameter int RES_DEPTH = 8,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  dot_batch_feeder_if.slave    bus,
  output logic                 o_busy,
  output logic                 o_err_done,
  output logic [CNT_WIDTH-1:0] o_issued
);
  localparam int CW = $clog2(RES_DEPTH) + 1;

  weight_vec_t          r_wbuf [2];
  act_vec_t             r_abuf [2];
  logic [1:0]           r_full;
  logic                 r_wr_sel;
  logic                 r_rd_sel;
  logic [BEAT_W-1:0]    r_beat_cnt;
  logic [CW-1:0]        r_outstanding;
  logic                 r_start;
  weight_vec_t          r_wflat;
  act_vec_t             r_aflat;
  logic                 r_err;
  logic [CNT_WIDTH-1:0] r_issued;

  logic                 w_accept;
  logic                 w_last_beat;
  logic                 w_issue;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_fifo_empty;
  logic [CW-1:0]        w_fifo_count;
  logic [CW:0]          w_credit_sum;

  assign bus.s_ready  = !r_full[r_wr_sel];
  assign w_accept     = bus.s_valid && bus.s_ready;
  assign w_last_beat  = (r_beat_cnt == BEAT_W'(BEATS - 1));
  // Results in flight plus results waiting must never exceed FIFO space.
  assign w_credit_sum = {1'b0, r_outstanding} + {1'b0, w_fifo_count};
  assign w_issue      = r_full[r_rd_sel] && (w_credit_sum < (CW+1)'(RES_DEPTH));
  assign w_push       = bus.i_done && (r_outstanding != '0);
  assign w_pop        = !w_fifo_empty && bus.m_ready;

  always_ff @(posedge clk) begin
    if (w_accept && !rst) begin
      if (r_wr_sel) begin
        r_wbuf[1][int'(r_beat_cnt)*LANES*WEIGHT_WIDTH +: LANES*WEIGHT_WIDTH] <= bus.s_weights;
        r_abuf[1][int'(r_beat_cnt)*LANES*ACT_WIDTH +: LANES*ACT_WIDTH]       <= bus.s_acts;
      end else begin
        r_wbuf[0][int'(r_beat_cnt)*LANES*WEIGHT_WIDTH +: LANES*WEIGHT_WIDTH] <= bus.s_weights;
        r_abuf[0][int'(r_beat_cnt)*LANES*ACT_WIDTH +: LANES*ACT_WIDTH]       <= bus.s_acts;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_full        <= '0;
      r_wr_sel      <= 1'b0;
      r_rd_sel      <= 1'b0;
      r_beat_cnt    <= '0;
      r_outstanding <= '0;
      r_start       <= 1'b0;
      r_wflat       <= '0;
      r_aflat       <= '0;
      r_err         <= 1'b0;
      r_issued      <= '0;
    end else begin
      r_start <= w_issue;
      if (w_accept) begin
        if (w_last_beat) begin
          r_full[r_wr_sel] <= 1'b1;
          r_wr_sel         <= !r_wr_sel;
          r_beat_cnt       <= '0;
        end else begin
          r_beat_cnt <= r_beat_cnt + 1'b1;
        end
      end
      // The fill side only ever touches a non-full buffer, so set and clear never collide.
      if (w_issue) begin
        r_full[r_rd_sel] <= 1'b0;
        r_rd_sel         <= !r_rd_sel;
        r_wflat          <= r_wbuf[r_rd_sel];
        r_aflat          <= r_abuf[r_rd_sel];
        r_issued         <= r_issued + 1'b1;
      end
      r_outstanding <= r_outstanding + CW'(w_issue) - CW'(w_push);
      if (bus.i_done && (r_outstanding == '0)) r_err <= 1'b1;
    end
  end

  dot_result_fifo #(.DEPTH(RES_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_push  (w_push),
    .i_data  (bus.i_result),
    .i_pop   (w_pop),
    .o_data  (bus.m_result),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  assign bus.o_start        = r_start;
  assign bus.o_weights_flat = r_wflat;
  assign bus.o_acts_flat    = r_aflat;
  assign bus.m_valid        = !w_fifo_empty;
  assign o_busy     = (|r_full) || (r_beat_cnt != '0) || (r_outstanding != '0) || !w_fifo_empty;
  assign o_err_done = r_err;
  assign o_issued   = r_issued;
endmodule

// File: tb/tb_dot_batch_feeder.sv
// tb/tb_dot_batch_feeder.sv - scoreboard bench for dot_batch_feeder with a naive_dot stub
module tb_dot_batch_feeder;
  import dot_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        o_busy;
  logic        o_err_done;
  logic [15:0] o_issued;

  dot_batch_feeder_if bus();

  dot_batch_feeder #(.RES_DEPTH(8), .CNT_WIDTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .o_busy     (o_busy),
    .o_err_done (o_err_done),
    .o_issued   (o_issued)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int n_starts = 0;
  int stub_delay = 3;
  int spur_req = 0;
  int spur_ack = 0;
  bit stub_en = 1'b1;
  int base;

  weight_vec_t exp_w[$];
  act_vec_t    exp_a[$];
  result_t     exp_res[$];
  result_t     stub_res[$];
  result_t     pend_val[$];
  int          pend_due[$];
  logic [3:0]  w_el[N];
  logic [3:0]  a_el[N];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_vec(input string nm, input weight_vec_t act, input weight_vec_t exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Scoreboard monitor
  initial forever begin
    @(negedge clk);
    if (!rst && bus.o_start) begin
      n_starts++;
      if (exp_w.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL start_unexpected: got start expected none");
      end else begin
        chk_vec("start_weights", bus.o_weights_flat, exp_w.pop_front());
        chk_vec("start_acts", bus.o_acts_flat, exp_a.pop_front());
      end
      if (stub_res.size() != 0) pend_val.push_back(stub_res.pop_front());
      else pend_val.push_back('0);
      pend_due.push_back(cyc + stub_delay);
    end
    if (!rst && bus.m_valid && bus.m_ready) begin
      if (exp_res.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL result_unexpected: got %0d expected none", bus.m_result);
      end else begin
        chk("result", bus.m_result, exp_res.pop_front());
      end
    end
  end

  // naive_dot stub
  initial begin
    bus.i_done   = 1'b0;
    bus.i_result = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.i_done = 1'b0;
      if (spur_req != spur_ack) begin
        spur_ack     = spur_req;
        bus.i_done   = 1'b1;
        bus.i_result = 16'sh7777;
      end else if (stub_en && pend_val.size() != 0 && cyc >= pend_due[0]) begin
        bus.i_done   = 1'b1;
        bus.i_result = pend_val.pop_front();
        void'(pend_due.pop_front());
      end
    end
  end

  task automatic send_batch(input int nbeats, input bit expect_it, input result_t res);
    weight_vec_t fw;
    act_vec_t    fa;
    int          tmo;
    for (int i = 0; i < N; i++) begin
      fw[i*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_el[i];
      fa[i*ACT_WIDTH +: ACT_WIDTH]       = a_el[i];
    end
    if (expect_it) begin
      exp_w.push_back(fw);
      exp_a.push_back(fa);
      stub_res.push_back(res);
      exp_res.push_back(res);
    end
    for (int b = 0; b < nbeats; b++) begin
      bus.s_valid = 1'b1;
      for (int j = 0; j < LANES; j++) begin
        bus.s_weights[j*WEIGHT_WIDTH +: WEIGHT_WIDTH] = w_el[b*LANES+j];
        bus.s_acts[j*ACT_WIDTH +: ACT_WIDTH]          = a_el[b*LANES+j];
      end
      tmo = 0;
      while (!bus.s_ready && tmo < 3000) begin
        @(posedge clk);
        #1;
        tmo++;
      end
      if (tmo >= 3000) begin
        n_cmp++;
        n_bad++;
        $display("FAIL s_ready_timeout: got ready=0 for %0d cycles expected ready", tmo);
        bus.s_valid = 1'b0;
        return;
      end
      @(posedge clk);
      #1;
    end
    bus.s_valid = 1'b0;
  endtask

  task automatic wait_idle(input string nm);
    int tmo = 0;
    while ((exp_res.size() != 0 || exp_w.size() != 0 || o_busy) && tmo < 3000) begin
      @(posedge clk);
      #1;
      tmo++;
    end
    chk({nm, "_idle_in_time"}, 64'(tmo < 3000), 1);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    bus.s_valid   = 1'b0;
    bus.s_weights = '0;
    bus.s_acts    = '0;
    bus.m_ready   = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_start", bus.o_start, 0);
    chk("rst_m_valid", bus.m_valid, 0);
    chk("rst_issued", o_issued, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_err", o_err_done, 0);
    chk_vec("rst_wflat", bus.o_weights_flat, '0);
    step(1);
    rst = 1'b0;

    // single batch: 128 * 1 * 2 = 256
    for (int i = 0; i < N; i++) begin w_el[i] = 4'h1; a_el[i] = 4'h2; end
    base = n_starts;
    send_batch(BEATS, 1'b1, 16'sd256);
    chk("t1_no_early_start", bus.o_start, 0);
    step(1);
    chk("t1_start_pulse", bus.o_start, 1);
    step(1);
    chk("t1_start_single", bus.o_start, 0);
    wait_idle("t1");
    chk("t1_starts", 64'(n_starts - base), 1);
    chk("t1_issued", o_issued, 1);
    chk("t1_busy", o_busy, 0);

    // element mapping: 8 * sum k*(15-k) = 4480
    for (int i = 0; i < N; i++) begin w_el[i] = 4'(i % 16); a_el[i] = 4'(15 - (i % 16)); end
    send_batch(BEATS, 1'b1, 16'sd4480);
    wait_idle("t2");
    chk("t2_issued", o_issued, 2);

    // ping-pong with stalled stub
    stub_en = 1'b0;
    base = n_starts;
    for (int b = 0; b < 3; b++) begin
      for (int i = 0; i < N; i++) begin w_el[i] = 4'(b + 3); a_el[i] = 4'(10 - b); end
      send_batch(BEATS, 1'b1, result_t'(100 + b));
    end
    step(10);
    chk("t3_issued", o_issued, 5);
    chk("t3_s_ready", bus.s_ready, 1);
    chk("t3_m_valid", bus.m_valid, 0);
    chk("t3_busy", o_busy, 1);
    stub_en = 1'b1;
    wait_idle("t3");
    chk("t3_starts", 64'(n_starts - base), 3);

    // credit limit
    bus.m_ready = 1'b0;
    stub_delay  = 0;
    base = n_starts;
    for (int k = 0; k < 10; k++) begin
      for (int i = 0; i < N; i++) begin w_el[i] = 4'(k); a_el[i] = 4'(k + 1); end
      send_batch(BEATS, 1'b1, result_t'(k));
    end
    step(10);
    chk("t4_starts_blocked", 64'(n_starts - base), 8);
    chk("t4_s_ready_low", bus.s_ready, 0);
    chk("t4_m_valid", bus.m_valid, 1);
    bus.m_ready = 1'b1;
    step(1);
    bus.m_ready = 1'b0;
    step(10);
    chk("t4_starts_after_pop", 64'(n_starts - base), 9);
    bus.m_ready = 1'b1;
    wait_idle("t4");
    chk("t4_starts_total", 64'(n_starts - base), 10);
    chk("t4_issued", o_issued, 15);

    // spurious done
    spur_req++;
    step(4);
    chk("t5_err_set", o_err_done, 1);
    chk("t5_fifo_empty", bus.m_valid, 0);
    step(5);
    chk("t5_err_sticky", o_err_done, 1);
    chk("t5_busy", o_busy, 0);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("t5_err_cleared", o_err_done, 0);
    chk("t5_issued_cleared", o_issued, 0);

    // reset mid-batch
    for (int i = 0; i < N; i++) begin w_el[i] = 4'hF; a_el[i] = 4'hF; end
    send_batch(5, 1'b0, '0);
    chk("t6_busy_partial", o_busy, 1);
    rst = 1'b1;
    step(2);
    rst = 1'b0;
    step(1);
    chk("t6_busy_after_rst", o_busy, 0);
    for (int i = 0; i < N; i++) begin w_el[i] = 4'h5; a_el[i] = 4'h3; end
    base = n_starts;
    send_batch(BEATS, 1'b1, 16'sd77);
    wait_idle("t6");
    chk("t6_starts", 64'(n_starts - base), 1);
    chk("t6_issued", o_issued, 1);

    chk("end_starts_pending", 64'(exp_w.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
